alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
Initiator side of the combinational MIPS ALU interface. It accepts one instruction plus register operands over a valid/ready handshake, and decodes opcode/funct into the 3-bit ALU control code. It drives registered A/B/control to the ALU, waits a fixed settle time, then captures Result/Zero. It returns the result, zero flag, branch decision and illegal flag over a second valid/ready handshake. It sits between the register-read stage and writeback/PC-select in the multi-cycle datapath.

Parameters:
SETTLE_CYCLES, 1, cycles ALU operands are held stable before capture; legal range 1..15
WIDTH, 32, datapath width; fixed at 32 for this design

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous reset, active-high
in_valid  input  1  instruction/operands valid
in_ready  output  1  unit can accept; high only in IDLE and reset deasserted
instr  input  32  MIPS instruction word
rs_val  input  32  register rs value
rt_val  input  32  register rt value
alu_a  output  32  ALU operand A (registered)
alu_b  output  32  ALU operand B (registered)
alu_cont  output  3  ALU control code (registered)
alu_result  input  32  ALU Result
alu_zero  input  1  ALU Zero
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  32  captured result
out_zero  output  1  captured zero flag
out_taken  output  1  branch taken (beq/bne only, else 0)
out_err  output  1  illegal instruction

Behaviour:
- Reset (async, active-high): state IDLE; alu_a, alu_b, out_result = 0; alu_cont = 3'b000; out_valid, out_zero, out_taken, out_err = 0; in_ready = 0 while reset is high. Reset in any state aborts the operation, with no out_valid pulse.
- States: IDLE -> EXEC -> DONE -> IDLE.
- IDLE: in_ready = 1. An edge with in_valid=1 is the accept edge. On it, load alu_a/alu_b/alu_cont and the decode flags, load the settle counter with SETTLE_CYCLES-1, and go to EXEC.
- EXEC: in_ready = 0. The counter decrements each cycle. On the edge where the counter is 0, capture alu_result/alu_zero into out_result/out_zero, compute out_taken, set out_valid = 1, and go to DONE.
- DONE: out_valid = 1 and all out_* stable until an edge with out_ready=1. On that edge, out_valid goes to 0 and the state returns to IDLE. A new accept is possible on the following edge (no same-cycle turnaround).
- Latency: accept at edge k; out_valid is high after edge k+SETTLE_CYCLES. Throughput is one instruction per SETTLE_CYCLES+2 cycles minimum.
- out_* and alu_* keep their last values until the next accept or capture. They are not cleared on handshake completion.
- Decode, R-type (opcode 6'h00) by funct:
  - 20 add -> 010
  - 22 sub -> 110
  - 24 and -> 000
  - 25 or -> 001
  - 2A slt -> 111
  - For all R-type: alu_b = rt_val.
- Decode, I-type, imm = instr[15:0]:
  - 08 addi -> 010, sign-extended imm
  - 0A slti -> 111, sign-extended imm
  - 0C andi -> 000, zero-extended imm
  - 0D ori -> 001, zero-extended imm
  - 04 beq -> 110, alu_b = rt_val
  - 05 bne -> 110, alu_b = rt_val
- alu_a = rs_val always.
- out_taken: beq -> alu_zero; bne -> ~alu_zero; otherwise 0.
- Any other opcode or funct is illegal:
  - alu_a, alu_b, alu_cont are loaded with 0; the FSM still runs EXEC for the full settle time.
  - At capture: out_result = 0, out_zero = 1, out_taken = 0, out_err = 1. ALU inputs are ignored.
- out_err = 0 for every legal instruction.
- The unit does no arithmetic; slt semantics (sign of A-B) and Zero are whatever the ALU returns.
- in_valid while not IDLE is ignored. instr, rs_val and rt_val need only be stable on the accept edge.

Test Plan:
- Add: SETTLE_CYCLES=1, add with rs=5, rt=7 -> alu_cont=010; out_valid after edge k+1; out_result=12, out_zero=0, out_err=0.
- beq/bne: beq with rs=rt=0x1234 -> alu_cont=110, out_zero=1, out_taken=1. bne with the same operands -> out_taken=0. bne with rs=1, rt=2 -> out_taken=1.
- Immediate extension: andi rs=0xFFFFFFFF, imm=0x8001 -> alu_b=0x00008001, result 0x00008001. addi rs=0, imm=0xFFFF -> alu_b=0xFFFFFFFF. slti rs=0xFFFFFFFF, imm=0 -> alu_cont=111, result 1.
- Backpressure and settle: SETTLE_CYCLES=4, out_ready=0 for 6 cycles with in_valid held high -> out_valid first high 4 edges after accept; in_ready=0 throughout; out_* unchanged. The second instruction is accepted only after the out_ready handshake plus one IDLE cycle.
- Illegal: opcode 0x23 (lw) -> out_err=1, out_result=0, out_zero=1, out_taken=0, alu_cont=000. R-type funct 0x27 -> same response.
- Reset mid-EXEC: SETTLE_CYCLES=3, assert reset one cycle after accept -> all outputs 0 immediately (asynchronous); no out_valid ever; after deassert, in_ready=1 and the next add completes normally.

Source files
------------

// File: rtl/alu_issue_unit.sv
// Issue side of the combinational MIPS ALU: decodes one instruction, drives
// registered operands, waits SETTLE_CYCLES, then returns the captured result.
`timescale 1ns/1ps
module alu_issue_unit #(
   parameter int SETTLE_CYCLES = 1,
   parameter int WIDTH         = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_cont,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_taken,
   output logic             out_err
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t     state;
   logic [3:0] cnt;
   logic       is_beq, is_bne, illegal;

   logic [5:0]       opcode, funct;
   logic [15:0]      imm;
   logic             dec_ok, dec_beq, dec_bne;
   logic [2:0]       dec_cont;
   logic [WIDTH-1:0] dec_b;
   logic             unused_fields;

   assign opcode        = instr[31:26];
   assign funct         = instr[5:0];
   assign imm           = instr[15:0];
   assign unused_fields = ^instr[25:16];

   always_comb begin
      dec_ok   = 1'b1;
      dec_beq  = 1'b0;
      dec_bne  = 1'b0;
      dec_cont = 3'b000;
      dec_b    = rt_val;
      case (opcode)
         6'h00: begin
            case (funct)
               6'h20:   dec_cont = 3'b010;
               6'h22:   dec_cont = 3'b110;
               6'h24:   dec_cont = 3'b000;
               6'h25:   dec_cont = 3'b001;
               6'h2A:   dec_cont = 3'b111;
               default: dec_ok   = 1'b0;
            endcase
         end
         6'h08: begin dec_cont = 3'b010; dec_b = {{(WIDTH-16){imm[15]}}, imm}; end
         6'h0A: begin dec_cont = 3'b111; dec_b = {{(WIDTH-16){imm[15]}}, imm}; end
         6'h0C: begin dec_cont = 3'b000; dec_b = {{(WIDTH-16){1'b0}}, imm}; end
         6'h0D: begin dec_cont = 3'b001; dec_b = {{(WIDTH-16){1'b0}}, imm}; end
         6'h04: begin dec_cont = 3'b110; dec_beq = 1'b1; end
         6'h05: begin dec_cont = 3'b110; dec_bne = 1'b1; end
         default: dec_ok = 1'b0;
      endcase
   end

   assign in_ready = (state == IDLE) && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         is_beq     <= 1'b0;
         is_bne     <= 1'b0;
         illegal    <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_cont   <= 3'b000;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_zero   <= 1'b0;
         out_taken  <= 1'b0;
         out_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  // Illegal instructions park the ALU on all-zero inputs.
                  alu_a    <= dec_ok ? rs_val : '0;
                  alu_b    <= dec_ok ? dec_b : '0;
                  alu_cont <= dec_ok ? dec_cont : 3'b000;
                  illegal  <= !dec_ok;
                  is_beq   <= dec_ok && dec_beq;
                  is_bne   <= dec_ok && dec_bne;
                  cnt      <= 4'(SETTLE_CYCLES - 1);
                  state    <= EXEC;
               end
            end
            EXEC: begin
               if (cnt == 4'd0) begin
                  if (illegal) begin
                     out_result <= '0;
                     out_zero   <= 1'b1;
                     out_taken  <= 1'b0;
                     out_err    <= 1'b1;
                  end else begin
                     out_result <= alu_result;
                     out_zero   <= alu_zero;
                     out_taken  <= (is_beq && alu_zero) || (is_bne && !alu_zero);
                     out_err    <= 1'b0;
                  end
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: three instances (settle 1, 4, 3) driven by
// directed steps, with a behavioural ALU and an expected-result queue.
`timescale 1ns/1ps
module tb_alu_issue_unit;

   typedef struct {
      logic [31:0] a, b, res;
      logic [2:0]  cont;
      logic        zero, taken, err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr, rs_val, rt_val;
   logic        in_valid [3];
   logic        out_ready[3];
   logic        in_ready [3];
   logic        out_valid[3];
   logic        out_zero [3];
   logic        out_taken[3];
   logic        out_err  [3];
   logic        alu_zero [3];
   logic [31:0] alu_a     [3];
   logic [31:0] alu_b     [3];
   logic [31:0] alu_result[3];
   logic [31:0] out_result[3];
   logic [2:0]  alu_cont  [3];

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [2:0] c);
      case (c)
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   for (genvar i = 0; i < 3; i++) begin : g_alu
      assign alu_result[i] = alu_f(alu_a[i], alu_b[i], alu_cont[i]);
      assign alu_zero[i]   = (alu_result[i] == 32'd0);
   end

   alu_issue_unit #(.SETTLE_CYCLES(1)) u0 (
      .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
      .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_cont(alu_cont[0]),
      .alu_result(alu_result[0]), .alu_zero(alu_zero[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_result(out_result[0]),
      .out_zero(out_zero[0]), .out_taken(out_taken[0]), .out_err(out_err[0]));

   alu_issue_unit #(.SETTLE_CYCLES(4)) u1 (
      .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
      .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_cont(alu_cont[1]),
      .alu_result(alu_result[1]), .alu_zero(alu_zero[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_result(out_result[1]),
      .out_zero(out_zero[1]), .out_taken(out_taken[1]), .out_err(out_err[1]));

   alu_issue_unit #(.SETTLE_CYCLES(3)) u2 (
      .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
      .alu_a(alu_a[2]), .alu_b(alu_b[2]), .alu_cont(alu_cont[2]),
      .alu_result(alu_result[2]), .alu_zero(alu_zero[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_result(out_result[2]),
      .out_zero(out_zero[2]), .out_taken(out_taken[2]), .out_err(out_err[2]));

   function automatic int settle(int idx);
      return (idx == 0) ? 1 : (idx == 1) ? 4 : 3;
   endfunction

   function automatic logic [31:0] rtype(logic [5:0] fn);
      return {6'h00, 20'h0, fn};
   endfunction

   function automatic logic [31:0] itype(logic [5:0] op, logic [15:0] im);
      return {op, 10'h0, im};
   endfunction

   function automatic exp_t mk(logic [31:0] a, logic [31:0] b, logic [2:0] c,
                               logic [31:0] res, logic z, logic t, logic er);
      exp_t e;
      e.a = a; e.b = b; e.cont = c; e.res = res; e.zero = z; e.taken = t; e.err = er;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one instruction and check the operands driven to the ALU.
   task automatic issue(input int idx, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input exp_t e, input bit keep);
      @(negedge clk);
      instr = ins; rs_val = rs; rt_val = rt; in_valid[idx] = 1'b1;
      sb.push_back(e);
      chk("in_ready_idle", 32'(in_ready[idx]), 32'd1);
      @(posedge clk); #1;
      if (!keep) in_valid[idx] = 1'b0;
      chk("alu_a", alu_a[idx], e.a);
      chk("alu_b", alu_b[idx], e.b);
      chk("alu_cont", 32'(alu_cont[idx]), 32'(e.cont));
      chk("in_ready_exec", 32'(in_ready[idx]), 32'd0);
   endtask

   // Wait for the result, compare, hold off for bp cycles, then handshake.
   task automatic complete(input int idx, input int bp);
      exp_t e;
      int   n = 0;
      e = sb.pop_front();
      while (out_valid[idx] !== 1'b1 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      chk("latency", 32'(n), 32'(settle(idx)));
      chk("out_result", out_result[idx], e.res);
      chk("out_zero", 32'(out_zero[idx]), 32'(e.zero));
      chk("out_taken", 32'(out_taken[idx]), 32'(e.taken));
      chk("out_err", 32'(out_err[idx]), 32'(e.err));
      for (int k = 0; k < bp; k++) begin
         @(posedge clk); #1;
         chk("bp_out_valid", 32'(out_valid[idx]), 32'd1);
         chk("bp_in_ready", 32'(in_ready[idx]), 32'd0);
         chk("bp_out_result", out_result[idx], e.res);
         chk("bp_alu_a", alu_a[idx], e.a);
      end
      @(negedge clk); out_ready[idx] = 1'b1;
      @(posedge clk); #1; out_ready[idx] = 1'b0;
      chk("hs_out_valid", 32'(out_valid[idx]), 32'd0);
      chk("hs_in_ready", 32'(in_ready[idx]), 32'd1);
      chk("hs_result_kept", out_result[idx], e.res);
   endtask

   initial begin
      exp_t dummy;
      reset = 1'b1;
      instr = '0; rs_val = '0; rt_val = '0;
      for (int i = 0; i < 3; i++) begin in_valid[i] = 1'b0; out_ready[i] = 1'b0; end
      #12;
      chk("rst_in_ready", 32'(in_ready[0]), 32'd0);
      chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
      chk("rst_alu_a", alu_a[0], 32'd0);
      chk("rst_alu_cont", 32'(alu_cont[0]), 32'd0);
      chk("rst_out_err", 32'(out_err[0]), 32'd0);
      @(negedge clk); reset = 1'b0;

      // Settle = 1: legal ops, branches, immediate extension, illegal.
      issue(0, rtype(6'h20), 32'd5, 32'd7, mk(32'd5, 32'd7, 3'b010, 32'd12, 0, 0, 0), 0);
      complete(0, 0);
      issue(0, itype(6'h04, 16'h0010), 32'h1234, 32'h1234,
            mk(32'h1234, 32'h1234, 3'b110, 32'd0, 1, 1, 0), 0);
      complete(0, 0);
      issue(0, itype(6'h05, 16'h0010), 32'h1234, 32'h1234,
            mk(32'h1234, 32'h1234, 3'b110, 32'd0, 1, 0, 0), 0);
      complete(0, 0);
      issue(0, itype(6'h05, 16'h0010), 32'd1, 32'd2,
            mk(32'd1, 32'd2, 3'b110, 32'hFFFF_FFFF, 0, 1, 0), 0);
      complete(0, 0);
      issue(0, itype(6'h0C, 16'h8001), 32'hFFFF_FFFF, 32'h5555,
            mk(32'hFFFF_FFFF, 32'h0000_8001, 3'b000, 32'h0000_8001, 0, 0, 0), 0);
      complete(0, 0);
      issue(0, itype(6'h08, 16'hFFFF), 32'd0, 32'h5555,
            mk(32'd0, 32'hFFFF_FFFF, 3'b010, 32'hFFFF_FFFF, 0, 0, 0), 0);
      complete(0, 0);
      issue(0, itype(6'h0A, 16'h0000), 32'hFFFF_FFFF, 32'h5555,
            mk(32'hFFFF_FFFF, 32'd0, 3'b111, 32'd1, 0, 0, 0), 0);
      complete(0, 0);
      issue(0, itype(6'h0D, 16'h8000), 32'd1, 32'h5555,
            mk(32'd1, 32'h0000_8000, 3'b001, 32'h0000_8001, 0, 0, 0), 0);
      complete(0, 0);
      issue(0, rtype(6'h22), 32'd10, 32'd3, mk(32'd10, 32'd3, 3'b110, 32'd7, 0, 0, 0), 0);
      complete(0, 0);
      issue(0, rtype(6'h25), 32'hF0, 32'h0F, mk(32'hF0, 32'h0F, 3'b001, 32'hFF, 0, 0, 0), 0);
      complete(0, 0);
      issue(0, rtype(6'h24), 32'hF0, 32'h0F, mk(32'hF0, 32'h0F, 3'b000, 32'h0, 1, 0, 0), 0);
      complete(0, 0);
      issue(0, itype(6'h23, 16'h0004), 32'hDEAD, 32'hBEEF, mk(32'd0, 32'd0, 3'b000, 32'd0, 1, 0, 1), 0);
      complete(0, 0);
      issue(0, rtype(6'h27), 32'hDEAD, 32'hBEEF, mk(32'd0, 32'd0, 3'b000, 32'd0, 1, 0, 1), 0);
      complete(0, 0);

      // Settle = 4 with backpressure; in_valid stays high the whole time.
      issue(1, rtype(6'h20), 32'd100, 32'd23, mk(32'd100, 32'd23, 3'b010, 32'd123, 0, 0, 0), 1);
      @(negedge clk);
      instr = rtype(6'h22); rs_val = 32'd50; rt_val = 32'd8;
      sb.push_back(mk(32'd50, 32'd8, 3'b110, 32'd42, 0, 0, 0));
      #1;
      complete(1, 6);
      chk("no_early_accept", alu_a[1], 32'd100);
      @(posedge clk); #1; in_valid[1] = 1'b0;
      chk("second_accept_a", alu_a[1], 32'd50);
      chk("second_accept_cont", 32'(alu_cont[1]), 32'b110);
      chk("second_in_ready", 32'(in_ready[1]), 32'd0);
      complete(1, 0);

      // Settle = 3: reset one cycle into EXEC aborts the operation.
      issue(2, rtype(6'h20), 32'd3, 32'd4, mk(32'd3, 32'd4, 3'b010, 32'd7, 0, 0, 0), 0);
      dummy = sb.pop_front();
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("arst_alu_a", alu_a[2], 32'd0);
      chk("arst_alu_b", alu_b[2], 32'd0);
      chk("arst_alu_cont", 32'(alu_cont[2]), 32'd0);
      chk("arst_in_ready", 32'(in_ready[2]), 32'd0);
      chk("arst_out_result", out_result[2], 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         chk("arst_no_out_valid", 32'(out_valid[2]), 32'd0);
      end
      chk("arst_idle_ready", 32'(in_ready[2]), 32'd1);
      issue(2, rtype(6'h20), 32'd20, 32'd22, mk(32'd20, 32'd22, 3'b010, 32'd42, 0, 0, 0), 0);
      complete(2, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
